// File: rtl/mimi_pkg.sv
// Shared definitions for the minimax Wishbone program loader.
package mimi_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCESS,
    S_CAPTURE,
    S_WRITE,
    S_ACK
  } state_t;

  // CTRL register bit positions
  localparam int unsigned CTRL_RUN     = 0;
  localparam int unsigned CTRL_DENIED  = 1;

  // Default wbs_adr_i bit that selects CTRL over RAM
  localparam int unsigned CTRL_BIT_DEF = 15;

  // CTRL readback: run and denied, all other bits zero
  function automatic logic [31:0] ctrl_word(input logic run, input logic denied);
    logic [31:0] w;
    w              = '0;
    w[CTRL_RUN]    = run;
    w[CTRL_DENIED] = denied;
    return w;
  endfunction

endpackage

// File: rtl/mimi_byte_merge.sv
// Byte-lane merge for partial writes: lanes with sel set take the new word,
// the rest keep the old word.
module mimi_byte_merge (
  input  logic [31:0] old_word,
  input  logic [31:0] new_word,
  input  logic [3:0]  sel,
  output logic [31:0] merged
);

  // Per-lane select between old and new byte
  always_comb begin
    merged = old_word;
    for (int unsigned i = 0; i < 4; i++) begin
      if (sel[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
  end

endmodule

// File: rtl/mimi_wb_loader.sv
// Wishbone slave at 0x3000_xxxx that loads/reads back the minimax program SRAM
// while the core is held in reset, plus a CTRL register (run, denied).
// Optional feature: define MIMI_WB_RMW_EN to make partial-byte writes perform a
// read-modify-write; otherwise partial writes leave RAM untouched and set denied.
module mimi_wb_loader
  import mimi_pkg::*;
#(
  parameter logic [15:0] WB_BASE_HI = 16'h3000,
  parameter int unsigned RAM_AW     = 11,
  parameter int unsigned CTRL_BIT   = CTRL_BIT_DEF
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_dat_i,
  input  logic [31:0]       wbs_adr_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  output logic              ram_en_o,
  output logic              ram_wen_o,
  output logic [RAM_AW-1:0] ram_addr_o,
  output logic [31:0]       ram_wdata_o,
  input  logic [31:0]       ram_rdata_i,
  output logic              cpu_reset_o
);

  state_t              state_q, state_d;
  logic                run_q, run_d;
  logic                denied_q, denied_d;
  logic [31:0]         cap_q, cap_d;
  logic                req_we_q, req_we_d;
  logic                req_ctrl_q, req_ctrl_d;
  logic                req_rmw_q, req_rmw_d;
  logic                ack_d;
  logic [31:0]         dat_d;
  logic                en_d, wen_d;
  logic [RAM_AW-1:0]   addr_d;
  logic [31:0]         wdata_d;
  logic                sel_hit;
  logic                unused_adr;

`ifdef MIMI_WB_RMW_EN
  logic [3:0]          req_sel_q, req_sel_d;
  logic [31:0]         merged;

  // New data is parked in ram_wdata_o during the read phase, so merge against it
  mimi_byte_merge u_merge (
    .old_word (ram_rdata_i),
    .new_word (ram_wdata_o),
    .sel      (req_sel_q),
    .merged   (merged)
  );
`endif

  assign sel_hit     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:16] == WB_BASE_HI);
  assign cpu_reset_o = ~run_q;
  assign unused_adr  = ^{wbs_adr_i[14:13], wbs_adr_i[1:0]};

  // Next-state and next registered-output logic
  always_comb begin
    state_d    = state_q;
    run_d      = run_q;
    denied_d   = denied_q;
    cap_d      = cap_q;
    req_we_d   = req_we_q;
    req_ctrl_d = req_ctrl_q;
    req_rmw_d  = req_rmw_q;
    ack_d      = 1'b0;
    dat_d      = '0;
    en_d       = 1'b0;
    wen_d      = 1'b0;
    addr_d     = ram_addr_o;
    wdata_d    = ram_wdata_o;
`ifdef MIMI_WB_RMW_EN
    req_sel_d  = req_sel_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        // The ack guard stops the still-asserted strobe of the finishing cycle
        // from being taken as a new request.
        if (sel_hit && !wbs_ack_o) begin
          req_we_d   = wbs_we_i;
          req_ctrl_d = wbs_adr_i[CTRL_BIT];
          req_rmw_d  = 1'b0;
          addr_d     = wbs_adr_i[RAM_AW+1:2];
          if (wbs_adr_i[CTRL_BIT]) begin
            state_d = S_ACK;
            if (wbs_we_i && wbs_sel_i[0]) begin
              run_d = wbs_dat_i[CTRL_RUN];
              if (wbs_dat_i[CTRL_DENIED]) denied_d = 1'b0;
            end
          end else if (run_q) begin
            denied_d = 1'b1;
            cap_d    = '0;
            state_d  = S_ACK;
          end else if (!wbs_we_i) begin
            en_d    = 1'b1;
            state_d = S_ACCESS;
          end else if (wbs_sel_i == 4'hf) begin
            en_d    = 1'b1;
            wen_d   = 1'b1;
            wdata_d = wbs_dat_i;
            state_d = S_ACCESS;
          end else if (wbs_sel_i == 4'h0) begin
            state_d = S_ACCESS;
          end else begin
`ifdef MIMI_WB_RMW_EN
            en_d      = 1'b1;
            wdata_d   = wbs_dat_i;
            req_rmw_d = 1'b1;
            req_sel_d = wbs_sel_i;
`else
            denied_d  = 1'b1;
`endif
            state_d = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        if (!wbs_cyc_i)                   state_d = S_IDLE;
        else if (req_rmw_q || !req_we_q)  state_d = S_CAPTURE;
        else                              state_d = S_ACK;
      end
      S_CAPTURE: begin
        cap_d   = ram_rdata_i;
        state_d = wbs_cyc_i ? S_ACK : S_IDLE;
`ifdef MIMI_WB_RMW_EN
        if (req_rmw_q) begin
          state_d = wbs_cyc_i ? S_WRITE : S_IDLE;
          if (wbs_cyc_i) begin
            en_d    = 1'b1;
            wen_d   = 1'b1;
            wdata_d = merged;
          end
        end
`endif
      end
      S_WRITE: begin
        state_d = wbs_cyc_i ? S_ACK : S_IDLE;
      end
      S_ACK: begin
        state_d = S_IDLE;
        ack_d   = wbs_cyc_i;
        if (wbs_cyc_i && !req_we_q)
          dat_d = req_ctrl_q ? ctrl_word(run_q, denied_q) : cap_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, control and registered bus/RAM outputs
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= S_IDLE;
      run_q       <= 1'b0;
      denied_q    <= 1'b0;
      cap_q       <= '0;
      req_we_q    <= 1'b0;
      req_ctrl_q  <= 1'b0;
      req_rmw_q   <= 1'b0;
      wbs_ack_o   <= 1'b0;
      wbs_dat_o   <= '0;
      ram_en_o    <= 1'b0;
      ram_wen_o   <= 1'b0;
      ram_addr_o  <= '0;
      ram_wdata_o <= '0;
`ifdef MIMI_WB_RMW_EN
      req_sel_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      denied_q    <= denied_d;
      cap_q       <= cap_d;
      req_we_q    <= req_we_d;
      req_ctrl_q  <= req_ctrl_d;
      req_rmw_q   <= req_rmw_d;
      wbs_ack_o   <= ack_d;
      wbs_dat_o   <= dat_d;
      ram_en_o    <= en_d;
      ram_wen_o   <= wen_d;
      ram_addr_o  <= addr_d;
      ram_wdata_o <= wdata_d;
`ifdef MIMI_WB_RMW_EN
      req_sel_q   <= req_sel_d;
`endif
    end
  end

endmodule

// File: tb/tb_mimi_wb_loader.sv
// Self-checking bench for mimi_wb_loader (default build and MIMI_WB_RMW_EN build).
module tb_mimi_wb_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = '0;
  logic [31:0] dat = '0, adr = '0;
  logic        ack, ram_en, ram_wen, cpu_reset;
  logic [31:0] rdat, ram_wdata, ram_rdata = '0;
  logic [10:0] ram_addr;

  always #5 clk = ~clk;

  mimi_wb_loader #(.WB_BASE_HI(16'h3000), .RAM_AW(11), .CTRL_BIT(15)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc),
    .wbs_we_i(we), .wbs_sel_i(sel), .wbs_dat_i(dat), .wbs_adr_i(adr),
    .wbs_ack_o(ack), .wbs_dat_o(rdat), .ram_en_o(ram_en), .ram_wen_o(ram_wen),
    .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata),
    .cpu_reset_o(cpu_reset)
  );

  // Physical SRAM stand-in: one-cycle read latency, read-first
  logic [31:0] phys [2048];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_wen) phys[ram_addr] <= ram_wdata;
      ram_rdata <= phys[ram_addr];
    end
  end

  // Specification-level model
  logic [31:0] mdl_mem [2048];
  bit          mdl_run, mdl_denied;

  int errors = 0, checks = 0;

  // Per-transaction expectations
  int          exp_lat;
  bit          exp_rd, exp_ram, exp_wen0;
  logic [31:0] exp_dat, exp_wdata;
  logic [10:0] exp_addr;
  int          txn_k;
  bit          txn_active = 0;
  int          last_lat;
  logic [31:0] last_dat;
  logic [10:0] last_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic predict(input bit w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    logic [31:0] mask;
    exp_lat = -1; exp_rd = 0; exp_ram = 0; exp_wen0 = 0;
    exp_addr = a[12:2]; exp_wdata = d; exp_dat = '0;
    if (a[31:16] != 16'h3000) return;
    if (a[15]) begin
      exp_lat = 1;
      if (w) begin
        if (s[0]) begin
          mdl_run = d[0];
          if (d[1]) mdl_denied = 0;
        end
      end else begin
        exp_rd  = 1;
        exp_dat = {30'd0, mdl_denied, mdl_run};
      end
    end else if (mdl_run) begin
      exp_lat = 1; mdl_denied = 1; exp_rd = !w; exp_dat = '0;
    end else if (!w) begin
      exp_lat = 3; exp_rd = 1; exp_ram = 1; exp_dat = mdl_mem[a[12:2]];
    end else if (s == 4'hf) begin
      exp_lat = 2; exp_ram = 1; exp_wen0 = 1; mdl_mem[a[12:2]] = d;
    end else if (s == 4'h0) begin
      exp_lat = 2;
    end else begin
`ifdef MIMI_WB_RMW_EN
      mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
      exp_lat = 4; exp_ram = 1;
      exp_wdata = (mdl_mem[a[12:2]] & ~mask) | (d & mask);
      mdl_mem[a[12:2]] = exp_wdata;
`else
      mask = '0;
      exp_lat = 2; mdl_denied = 1;
`endif
    end
  endtask

  // Single compare process: every cycle outside reset
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      chk("cpu_reset", {31'd0, cpu_reset}, {31'd0, !mdl_run});
      chk("wen_implies_en", {31'd0, ram_wen && !ram_en}, 32'd0);
      if (txn_active) begin
        txn_k++;
        if (!exp_ram) chk("no_ram_strobe", {31'd0, ram_en}, 32'd0);
        if (txn_k == 0) begin
          chk("ram_en_k0", {31'd0, ram_en}, {31'd0, exp_ram});
          if (exp_ram) begin
            chk("ram_addr", {21'd0, ram_addr}, {21'd0, exp_addr});
            chk("ram_wen_k0", {31'd0, ram_wen}, {31'd0, exp_wen0});
            if (exp_wen0) chk("ram_wdata", ram_wdata, exp_wdata);
          end
          if (ram_en) last_addr = ram_addr;
        end
        if (exp_lat == 4 && txn_k == 2) begin
          chk("rmw_en", {31'd0, ram_en}, 32'd1);
          chk("rmw_wen", {31'd0, ram_wen}, 32'd1);
          chk("rmw_wdata", ram_wdata, exp_wdata);
        end
        chk("ack", {31'd0, ack}, {31'd0, txn_k == exp_lat});
        if (ack) begin
          last_lat = txn_k;
          last_dat = rdat;
          if (exp_rd) chk("rdata", rdat, exp_dat);
        end
        if (txn_k >= ((exp_lat < 0) ? 5 : exp_lat + 1)) txn_active = 0;
      end
    end
  end

  task automatic xfer(input bit w, input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] d, input int drop_k = -1);
    @(negedge clk);
    cyc = 1; stb = 1; we = w; adr = a; sel = s; dat = d;
    last_lat = -1; last_dat = 'x;
    @(posedge clk);
    predict(w, a, s, d);
    if (drop_k >= 0) begin exp_lat = -1; exp_rd = 0; end
    txn_k = -1; txn_active = 1;
    for (int i = 0; i < 20 && txn_active; i++) begin
      @(negedge clk);
      if (drop_k >= 0 && txn_k == drop_k) begin cyc = 0; stb = 0; end
    end
    if (txn_active) begin
      checks++; errors++;
      $display("FAIL txn_timeout actual=active required=done (t=%0t)", $time);
      txn_active = 0;
    end
    cyc = 0; stb = 0; we = 0;
  endtask

  task automatic model_reset();
    mdl_run = 0; mdl_denied = 0;
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) begin phys[i] = '0; mdl_mem[i] = '0; end
    model_reset();
    #2 rst = 1;
    #1;
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_dat", rdat, 32'd0);
    chk("rst_en", {31'd0, ram_en}, 32'd0);
    chk("rst_wen", {31'd0, ram_wen}, 32'd0);
    chk("rst_addr", {21'd0, ram_addr}, 32'd0);
    chk("rst_wdata", ram_wdata, 32'd0);
    chk("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    @(negedge clk); @(negedge clk); rst = 0;

    // 1: reset clears run; reset mid-read aborts RAM access and ack
    xfer(1, 32'h3000_8000, 4'hf, 32'h1);
    chk("run_set_cpu_reset", {31'd0, cpu_reset}, 32'd0);
    @(negedge clk); rst = 1; model_reset(); #1;
    chk("rst_clears_run", {31'd0, cpu_reset}, 32'd1);
    @(negedge clk); rst = 0;
    @(negedge clk); cyc = 1; stb = 1; we = 0; adr = 32'h3000_0020; sel = 4'hf;
    @(negedge clk);
    chk("midread_en", {31'd0, ram_en}, 32'd1);
    rst = 1; model_reset(); #1;
    chk("midread_ack", {31'd0, ack}, 32'd0);
    chk("midread_en_cleared", {31'd0, ram_en}, 32'd0);
    chk("midread_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    cyc = 0; stb = 0;
    @(negedge clk); rst = 0;

    // 2: full write then readback
    xfer(1, 32'h3000_0010, 4'hf, 32'hDEAD_BEEF);
    chk("t2_addr_lit", {21'd0, last_addr}, 32'h4);
    chk("t2_wr_lat_lit", last_lat, 32'd2);
    xfer(0, 32'h3000_0010, 4'hf, 32'h0);
    chk("t2_rd_lat_lit", last_lat, 32'd3);
    chk("t2_rd_dat_lit", last_dat, 32'hDEAD_BEEF);
    xfer(1, 32'h3000_0014, 4'hf, 32'h1234_5678);
    xfer(1, 32'h3000_6010, 4'hf, 32'hCAFE_F00D);   // alias of word 4
    xfer(0, 32'h3000_0010, 4'hf, 32'h0);
    chk("alias_lit", last_dat, 32'hCAFE_F00D);
    xfer(1, 32'h3000_0014, 4'h0, 32'hFFFF_FFFF);   // sel=0: no RAM write
    xfer(0, 32'h3000_0014, 4'hf, 32'h0);
    chk("sel0_lit", last_dat, 32'h1234_5678);
    xfer(0, 32'h3100_0010, 4'hf, 32'h0);           // not selected

    // 3: run=1 blocks RAM and sets denied
    xfer(1, 32'h3000_8000, 4'hf, 32'h1);
    xfer(1, 32'h3000_0018, 4'hf, 32'h5555_5555);
    xfer(0, 32'h3000_0010, 4'hf, 32'h0);
    xfer(0, 32'h3000_8000, 4'hf, 32'h0);
    chk("t3_ctrl_lit", last_dat, 32'h3);

    // 4: W1C denied + run=0; top-of-RAM address
    xfer(1, 32'h3000_8000, 4'hf, 32'h2);
    xfer(0, 32'h3000_8000, 4'hf, 32'h0);
    chk("t4_ctrl_lit", last_dat, 32'h0);
    xfer(1, 32'h3000_8000, 4'he, 32'h1);           // sel[0]=0: ignored
    xfer(1, 32'h3000_1FFC, 4'hf, 32'hA5A5_5A5A);
    chk("t4_addr_lit", {21'd0, last_addr}, 32'h7FF);
    xfer(0, 32'h3000_1FFC, 4'hf, 32'h0);
    xfer(0, 32'h3000_0018, 4'hf, 32'h0);           // denied write left 0

    // 5: partial write
    xfer(1, 32'h3000_0040, 4'hf, 32'h1122_3344);
    xfer(1, 32'h3000_0040, 4'b0010, 32'h0000_AA00);
`ifdef MIMI_WB_RMW_EN
    chk("t5_lat_lit", last_lat, 32'd4);
    xfer(0, 32'h3000_0040, 4'hf, 32'h0);
    chk("t5_rmw_lit", last_dat, 32'h1122_AA44);
`else
    chk("t5_lat_lit", last_lat, 32'd2);
    xfer(0, 32'h3000_0040, 4'hf, 32'h0);
    chk("t5_norm_lit", last_dat, 32'h1122_3344);
    xfer(0, 32'h3000_8000, 4'hf, 32'h0);
    chk("t5_denied_lit", last_dat, 32'h2);
    xfer(1, 32'h3000_8000, 4'hf, 32'h2);
`endif

    // 6: cyc dropped in ACCESS, then a normal request
    xfer(0, 32'h3000_0040, 4'hf, 32'h0, 0);
    xfer(0, 32'h3000_0014, 4'hf, 32'h0);
    chk("t6_after_drop_lat", last_lat, 32'd3);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
